// File: rtl/sync_fwft_fifo_if.sv
// Handshake bundle between the acquisition front end, the FWFT FIFO and the
// downstream stream adapter. Signal names are from the FIFO's point of view.
interface sync_fwft_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  i_fifo_flush;
  logic                  i_fifo_w_stb;
  logic [DATA_WIDTH-1:0] i_fifo_w_data;
  logic                  o_fifo_not_full;
  logic [DATA_WIDTH-1:0] o_fifo_data;
  logic                  i_fifo_r_stb;
  logic                  o_fifo_not_empty;
  logic [ADDR_WIDTH:0]   o_fifo_count;
  logic                  o_fifo_overflow;
  logic                  o_fifo_underflow;

  modport master (
    output i_fifo_flush, i_fifo_w_stb, i_fifo_w_data, i_fifo_r_stb,
    input  o_fifo_not_full, o_fifo_data, o_fifo_not_empty, o_fifo_count,
           o_fifo_overflow, o_fifo_underflow
  );

  modport slave (
    input  i_fifo_flush, i_fifo_w_stb, i_fifo_w_data, i_fifo_r_stb,
    output o_fifo_not_full, o_fifo_data, o_fifo_not_empty, o_fifo_count,
           o_fifo_overflow, o_fifo_underflow
  );
endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, sticky
// overflow/underflow flags and a synchronous flush. All outputs are registered-state only.
module sync_fwft_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sync_fwft_fifo_if.slave      fifo
);
  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty, wr_acc, rd_acc;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // Acceptance looks only at registered occupancy, so a pop never frees room
  // for a same-cycle write into a full FIFO.
  assign wr_acc = fifo.i_fifo_w_stb && !full;
  assign rd_acc = fifo.i_fifo_r_stb && !empty;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (fifo.i_fifo_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (fifo.i_fifo_w_stb && full)  overflow_d  = 1'b1;
      if (fifo.i_fifo_r_stb && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy tracking makes stale words unobservable.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !fifo.i_fifo_flush && wr_acc) begin
      mem[wr_ptr_q] <= fifo.i_fifo_w_data;
    end
  end

  assign fifo.o_fifo_data      = mem[rd_ptr_q];
  assign fifo.o_fifo_not_empty = !empty;
  assign fifo.o_fifo_not_full  = !full;
  assign fifo.o_fifo_count     = count_q;
  assign fifo.o_fifo_overflow  = overflow_q;
  assign fifo.o_fifo_underflow = underflow_q;
endmodule
